// File: rtl/debug_step_scheduler.sv
`default_nettype none
// ============================================================================
// Module : debug_step_scheduler
// Steps/free-runs the MIPS pipeline, then streams PC, registers and data memory.
// Rev    : 1.0
// ============================================================================
module debug_step_scheduler #(
  parameter int NB          = 32,
  parameter int NB_REG_SEL  = 5,
  parameter int N_REGS      = 32,
  parameter int N_MEM_WORDS = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_cmd_valid,
  input  logic [1:0]            i_cmd,
  output logic                  o_cmd_ready,
  input  logic                  i_halt,
  output logic                  o_step,
  output logic [NB_REG_SEL-1:0] o_debug_reg_num,
  output logic [NB-1:0]         o_debug_address,
  input  logic [NB-1:0]         i_mips_pc,
  input  logic [NB-1:0]         i_mips_register_data,
  input  logic [NB-1:0]         i_mips_data_memory,
  output logic [NB-1:0]         o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic                  o_busy,
  output logic                  o_halted
);

  localparam int TOTAL = 1 + N_REGS + N_MEM_WORDS;
  localparam int IDX_W = $clog2(TOTAL + 1);
  localparam logic [IDX_W-1:0] c_last_idx  = IDX_W'(TOTAL - 1);
  localparam logic [IDX_W-1:0] c_n_regs    = IDX_W'(N_REGS);
  localparam logic [IDX_W-1:0] c_mem_base  = IDX_W'(N_REGS + 1);
  localparam logic [IDX_W-1:0] c_idx_one   = IDX_W'(1);
  localparam logic [1:0]       c_cmd_step  = 2'b00;
  localparam logic [1:0]       c_cmd_run   = 2'b01;
  localparam logic [1:0]       c_cmd_dump  = 2'b10;
  localparam logic [1:0]       c_cmd_abort = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_STEP = 3'd1,
    S_RUN  = 3'd2,
    S_ADDR = 3'd3,
    S_LOAD = 3'd4,
    S_SEND = 3'd5
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_halted;
  logic [NB_REG_SEL-1:0]   r_reg_num;
  logic [NB-1:0]           r_address;
  logic [NB-1:0]           r_tx_data;
  logic                    r_tx_valid;

  logic                    w_cmd_fire;
  logic                    w_abort;
  logic                    w_is_reg;
  logic                    w_is_mem;
  logic [NB_REG_SEL-1:0]   w_reg_sel;
  logic [IDX_W-1:0]        w_mem_off;
  logic [NB-1:0]           w_mem_addr;
  logic [NB-1:0]           w_load_word;

  assign o_cmd_ready = (r_state == S_IDLE) | (r_state == S_RUN);
  assign w_cmd_fire  = i_cmd_valid & o_cmd_ready;
  assign w_abort     = w_cmd_fire & (i_cmd == c_cmd_abort);

  // The cycle that ends a run (halt or abort) issues no step
  assign o_step = (r_state == S_STEP) | ((r_state == S_RUN) & ~i_halt & ~w_abort);
  assign o_busy = (r_state != S_IDLE);

  assign o_halted        = r_halted;
  assign o_debug_reg_num = r_reg_num;
  assign o_debug_address = r_address;
  assign o_tx_data       = r_tx_data;
  assign o_tx_valid      = r_tx_valid;

  // Word index map: 0 = PC, 1..N_REGS = registers, remainder = memory words
  assign w_is_reg    = (r_idx != '0) && (r_idx <= c_n_regs);
  assign w_is_mem    = (r_idx > c_n_regs);
  assign w_reg_sel   = NB_REG_SEL'(r_idx - c_idx_one);
  assign w_mem_off   = r_idx - c_mem_base;
  assign w_mem_addr  = NB'({w_mem_off, 2'b00});
  assign w_load_word = (r_idx == '0) ? i_mips_pc :
                       w_is_reg      ? i_mips_register_data :
                                       i_mips_data_memory;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_fire) begin
          case (i_cmd)
            c_cmd_step: w_next = r_halted ? S_ADDR : S_STEP;
            c_cmd_run:  w_next = r_halted ? S_ADDR : S_RUN;
            c_cmd_dump: w_next = S_ADDR;
            default:    w_next = S_IDLE;
          endcase
        end
      end
      S_STEP: w_next = S_ADDR;
      S_RUN: begin
        if (i_halt || w_abort) w_next = S_ADDR;
      end
      S_ADDR: w_next = S_LOAD;
      S_LOAD: w_next = S_SEND;
      S_SEND: begin
        if (i_tx_ready) w_next = (r_idx == c_last_idx) ? S_IDLE : S_ADDR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_halted   <= 1'b0;
      r_reg_num  <= '0;
      r_address  <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      if (((r_state == S_STEP) || (r_state == S_RUN)) && i_halt) r_halted <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_next != S_IDLE) r_idx <= '0;
        end
        S_ADDR: begin
          if (w_is_reg) r_reg_num <= w_reg_sel;
          if (w_is_mem) r_address <= w_mem_addr;
        end
        S_LOAD: begin
          r_tx_data  <= w_load_word;
          r_tx_valid <= 1'b1;
        end
        S_SEND: begin
          if (i_tx_ready) begin
            r_tx_valid <= 1'b0;
            if (r_idx != c_last_idx) r_idx <= r_idx + c_idx_one;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_debug_step_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_debug_step_scheduler
// Self-checking bench: directed vector table plus randomized command scenarios.
// Rev    : 1.0
// ============================================================================
module tb_debug_step_scheduler;

  localparam int NB          = 32;
  localparam int NB_REG_SEL  = 5;
  localparam int N_REGS      = 32;
  localparam int N_MEM_WORDS = 32;
  localparam int TOTAL       = 1 + N_REGS + N_MEM_WORDS;
  localparam logic [1:0] C_STEP  = 2'b00;
  localparam logic [1:0] C_RUN   = 2'b01;
  localparam logic [1:0] C_DUMP  = 2'b10;
  localparam logic [1:0] C_ABORT = 2'b11;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  cmd_valid;
  logic [1:0]            cmd_i;
  logic                  cmd_ready;
  logic                  halt;
  logic                  step;
  logic [NB_REG_SEL-1:0] dbg_reg;
  logic [NB-1:0]         dbg_addr;
  logic [NB-1:0]         pc;
  logic [NB-1:0]         reg_data;
  logic [NB-1:0]         mem_data;
  logic [NB-1:0]         tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  busy;
  logic                  halted;
  logic [31:0]           salt;

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  m_halted = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] reg_val(input logic [31:0] s, input logic [4:0] n);
    return s ^ (32'h0101_0101 * (32'(n) + 32'd1));
  endfunction

  function automatic logic [31:0] mem_val(input logic [31:0] s, input logic [31:0] a);
    return ~s + a * 32'd7 + 32'h100;
  endfunction

  // Pipeline stand-in: register file and data memory as pure functions of the debug ports
  assign reg_data = reg_val(salt, dbg_reg);
  assign mem_data = mem_val(salt, dbg_addr);

  debug_step_scheduler #(
    .NB(NB), .NB_REG_SEL(NB_REG_SEL), .N_REGS(N_REGS), .N_MEM_WORDS(N_MEM_WORDS)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_cmd_valid(cmd_valid), .i_cmd(cmd_i),
    .o_cmd_ready(cmd_ready), .i_halt(halt), .o_step(step),
    .o_debug_reg_num(dbg_reg), .o_debug_address(dbg_addr), .i_mips_pc(pc),
    .i_mips_register_data(reg_data), .i_mips_data_memory(mem_data),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
    .o_busy(busy), .o_halted(halted)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " o_step"},     64'(step), 0);
    check({tag, " o_busy"},     64'(busy), 0);
    check({tag, " o_tx_valid"}, 64'(tx_valid), 0);
    check({tag, " o_tx_data"},  64'(tx_data), 0);
    check({tag, " reg_num"},    64'(dbg_reg), 0);
    check({tag, " address"},    64'(dbg_addr), 0);
    check({tag, " o_halted"},   64'(halted), 0);
    check({tag, " cmd_ready"},  64'(cmd_ready), 1);
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0; halt = 1'b0; tx_ready = 1'b0; cmd_i = C_STEP;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    m_halted = 1'b0;
  endtask

  // Issue one command and follow it to the end of its dump, checking every word
  task automatic run_scn(input logic [1:0] cmd, input int h, input int a, input int noise_at,
                         input logic [1:0] noise_cmd, input int stall_word, input int ready_pct,
                         input int exp_pulses, input bit exp_halted, input int exp_words,
                         input string tag);
    logic [31:0] exp_q[$];
    int  pulses, words, stall_left, fin_k;
    bit  done, pv, pr;
    salt = $urandom;
    pc   = $urandom;
    exp_q.delete();
    if (exp_words != 0) begin
      exp_q.push_back(pc);
      for (int r = 0; r < N_REGS; r++) exp_q.push_back(reg_val(salt, 5'(r)));
      for (int m = 0; m < N_MEM_WORDS; m++) exp_q.push_back(mem_val(salt, 32'(m * 4)));
    end
    @(negedge clk);
    cmd_valid = 1'b1; cmd_i = cmd; tx_ready = 1'b0; halt = 1'b0;
    #1 check({tag, " cmd_ready"}, 64'(cmd_ready), 1);
    pulses = 0; words = 0; stall_left = 5; done = 1'b0; pv = 1'b0; pr = 1'b0;
    fin_k = (exp_words == 0) ? 4 : -1;
    for (int k = 1; k <= 3000 && !done; k++) begin
      @(negedge clk);
      halt = (h != 0) && (k >= h);
      cmd_valid = 1'b0;
      if (k == a) begin cmd_valid = 1'b1; cmd_i = C_ABORT; end
      else if (k == noise_at) begin cmd_valid = 1'b1; cmd_i = noise_cmd; end
      if (tx_valid && words == stall_word && stall_left > 0) begin
        tx_ready = 1'b0; stall_left--;
      end else begin
        tx_ready = ($urandom_range(0, 99) < ready_pct);
      end
      #1;
      if (step) pulses++;
      if (k == fin_k) begin
        check({tag, " busy after dump"}, 64'(busy), 0);
        check({tag, " valid after dump"}, 64'(tx_valid), 0);
        done = 1'b1;
      end else begin
        if (pv && !pr) check({tag, " valid held"}, 64'(tx_valid), 1);
        if (tx_valid) begin
          if (words < exp_q.size())
            check($sformatf("%s word%0d", tag, words), 64'(tx_data), 64'(exp_q[words]));
          else
            check({tag, " extra word"}, 64'(words), 64'(exp_q.size()));
        end
        pv = tx_valid; pr = tx_ready;
        if (tx_valid && tx_ready) begin
          words++;
          if (words == exp_words) fin_k = k + 1;
        end
      end
    end
    if (!done) check({tag, " timeout"}, 0, 1);
    check({tag, " pulses"}, 64'(pulses), 64'(exp_pulses));
    check({tag, " words"},  64'(words),  64'(exp_words));
    check({tag, " halted"}, 64'(halted), 64'(exp_halted));
    cmd_valid = 1'b0; halt = 1'b0; tx_ready = 1'b0;
  endtask

  task automatic mid_reset(input logic [1:0] cmd, input int cycles, input string tag);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_i = cmd; tx_ready = 1'b1; halt = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (cycles) @(negedge clk);
    #1;
    check({tag, " busy before reset"}, 64'(busy), 1);
    if (cmd == C_RUN) check({tag, " step before reset"}, 64'(step), 1);
    rst_n = 1'b0;
    #1 check_reset_outputs(tag);
    @(negedge clk); rst_n = 1'b1; m_halted = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check({tag, " no partial word"}, 64'(tx_valid), 0);
    check({tag, " idle after reset"}, 64'(busy), 0);
    tx_ready = 1'b0;
  endtask

  typedef struct {
    logic [1:0] cmd;
    int         h;
    int         a;
    int         stall;
    int         ready_pct;
    int         exp_pulses;
    bit         exp_halted;
    int         exp_words;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int cmd_r, h, a, noise, endc, ep, ew, rp;
    logic [1:0] c, ncmd;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_i = C_STEP; halt = 1'b0; tx_ready = 1'b0;
    salt = 32'h1234_5678; pc = 32'h0;
    #2 check_reset_outputs("por");
    @(negedge clk); @(negedge clk); rst_n = 1'b1;

    vecs[0] = '{C_STEP,  0,  0, -1, 100, 1, 1'b0, TOTAL};
    vecs[1] = '{C_ABORT, 0,  0, -1, 100, 0, 1'b0, 0};
    vecs[2] = '{C_DUMP,  0,  0,  3, 100, 0, 1'b0, TOTAL};
    vecs[3] = '{C_RUN,   0,  6, -1, 100, 5, 1'b0, TOTAL};
    vecs[4] = '{C_RUN,  10,  0, -1, 100, 9, 1'b1, TOTAL};
    vecs[5] = '{C_STEP,  0,  0, -1,  70, 0, 1'b1, TOTAL};
    vecs[6] = '{C_RUN,   0,  0, -1,  70, 0, 1'b1, TOTAL};
    for (int i = 0; i < 7; i++) begin
      run_scn(vecs[i].cmd, vecs[i].h, vecs[i].a, 0, C_STEP, vecs[i].stall, vecs[i].ready_pct,
              vecs[i].exp_pulses, vecs[i].exp_halted, vecs[i].exp_words,
              $sformatf("vec%0d", i));
      m_halted = vecs[i].exp_halted;
    end

    mid_reset(C_DUMP, 40, "rst_mid_dump");
    mid_reset(C_RUN, 4, "rst_mid_run");

    for (int i = 0; i < 14; i++) begin
      if (i % 4 == 3) do_reset();
      cmd_r = $urandom_range(0, 3);
      c = 2'(cmd_r);
      h = 0; a = 0; noise = 0; ncmd = C_STEP;
      if (c == C_STEP) h = $urandom_range(0, 1);
      if (c == C_RUN) begin
        h = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 25) : 0;
        a = (h == 0 || $urandom_range(0, 1) == 1) ? $urandom_range(1, 25) : 0;
      end
      ep = 0; ew = TOTAL;
      case (c)
        C_STEP: begin
          ep = m_halted ? 0 : 1;
          if (!m_halted && h == 1) m_halted = 1'b1;
        end
        C_RUN: begin
          if (!m_halted) begin
            endc = (h == 0) ? a : ((a == 0) ? h : ((h < a) ? h : a));
            ep = endc - 1;
            if (h != 0 && (a == 0 || h <= a)) m_halted = 1'b1;
            if (endc > 2) begin
              noise = $urandom_range(1, endc - 1);
              ncmd  = 2'($urandom_range(0, 2));
            end
          end
        end
        C_DUMP: ep = 0;
        default: begin ep = 0; ew = 0; end
      endcase
      rp = $urandom_range(40, 100);
      run_scn(c, h, a, noise, ncmd, -1, rp, ep, m_halted, ew, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
